// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and adder helper
// for the handshaked multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_ORR = 4'h1;
  localparam logic [3:0] OP_EOR = 4'h2;
  localparam logic [3:0] OP_BIC = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_MVN = 4'h5;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_ADC = 4'h7;
  localparam logic [3:0] OP_SUB = 4'h8;
  localparam logic [3:0] OP_SBC = 4'h9;
  localparam logic [3:0] OP_RSB = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_LSL = 4'hC;
  localparam logic [3:0] OP_LSR = 4'hD;
  localparam logic [3:0] OP_ASR = 4'hE;
  localparam logic [3:0] OP_ROR = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int ADD_W = 64;

  // {sum, carry, overflow}; msb is the sign bit
  // index of the active width, upper x/y bits are 0
  function automatic logic [ADD_W+1:0] flags_add(
    input logic [ADD_W-1:0] x,
    input logic [ADD_W-1:0] y,
    input logic             c_in,
    input logic [5:0]       msb
  );
    logic [ADD_W:0] s;
    logic [6:0]     ci;
    logic [6:0]     si;
    logic           cy;
    logic           ov;
    s  = {1'b0, x} + {1'b0, y}
       + {{ADD_W{1'b0}}, c_in};
    si = {1'b0, msb};
    ci = si + 7'd1;
    cy = s[ci];
    ov = (x[msb] == y[msb]) && (s[si] != x[msb]);
    return {s[ADD_W-1:0], cy, ov};
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter
// returning result and shifter carry-out.
module alu_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         kind,
  input  logic               cin,
  output logic [WIDTH-1:0]   result,
  output logic               carry
);

  localparam int LW = $clog2(WIDTH);

  logic [WIDTH:0]   lsl_t;
  logic [WIDTH:0]   lsr_t;
  logic [WIDTH:0]   asr_t;
  logic [WIDTH-1:0] ror_t;
  logic [LW-1:0]    rot;

  // one extra bit beside the operand catches the last bit out
  always_comb begin
    lsl_t  = {1'b0, a} << shamt;
    lsr_t  = {a, 1'b0} >> shamt;
    asr_t  = $signed({a, 1'b0}) >>> shamt;
    rot    = LW'(shamt);
    ror_t  = (a >> rot) | (a << (WIDTH - int'(rot)));
    result = a;
    carry  = cin;
    if (shamt != '0) begin
      unique case (kind)
        2'b00: begin
          result = lsl_t[WIDTH-1:0];
          carry  = lsl_t[WIDTH];
        end
        2'b01: begin
          result = lsr_t[WIDTH:1];
          carry  = lsr_t[0];
        end
        2'b10: begin
          result = asr_t[WIDTH:1];
          carry  = asr_t[0];
        end
        2'b11: begin
          result = ror_t;
          carry  = ror_t[WIDTH-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with NZCV flags,
// valid/ready channels and shift-add multiply.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               n,
  output logic               z,
  output logic               c,
  output logic               v,
  output logic               busy
);

  localparam int         CW  = $clog2(WIDTH);
  localparam logic [5:0] MSB = 6'(WIDTH - 1);

  state_t state_q;
  state_t state_d;
  logic   load;
  logic   mul_start;

  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic             ac;
  logic [ADD_W+1:0] add_r;
  logic [WIDTH-1:0] sum;
  logic             add_c;
  logic             add_v;
  logic             unused_add;

  logic [WIDTH-1:0] sh_res;
  logic             sh_c;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             mul_cin;

  logic [WIDTH-1:0] ld_res;
  logic             ld_c;
  logic             ld_v;

  // adder inputs after operand swap/inversion
  always_comb begin
    ax = a;
    ay = b;
    ac = 1'b0;
    unique case (op)
      OP_ADC: ac = cin;
      OP_SUB: begin
        ay = ~b;
        ac = 1'b1;
      end
      OP_SBC: begin
        ay = ~b;
        ac = cin;
      end
      OP_RSB: begin
        ax = b;
        ay = ~a;
        ac = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_r = flags_add(ADD_W'(ax), ADD_W'(ay),
                           ac, MSB);
  assign sum        = add_r[WIDTH+1:2];
  assign add_c      = add_r[1];
  assign add_v      = add_r[0];
  assign unused_add = ^add_r;

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .a      (a),
    .shamt  (b[SHAMT_W-1:0]),
    .kind   (op[1:0]),
    .cin    (cin),
    .result (sh_res),
    .carry  (sh_c)
  );

  // single-cycle result and flag selection
  always_comb begin
    alu_res = '0;
    alu_c   = cin;
    alu_v   = 1'b0;
    unique case (op)
      OP_AND: alu_res = a & b;
      OP_ORR: alu_res = a | b;
      OP_EOR: alu_res = a ^ b;
      OP_BIC: alu_res = a & ~b;
      OP_MOV: alu_res = b;
      OP_MVN: alu_res = ~b;
      OP_ADD, OP_ADC, OP_SUB,
      OP_SBC, OP_RSB: begin
        alu_res = sum;
        alu_c   = add_c;
        alu_v   = add_v;
      end
      OP_MUL: ;
      OP_LSL, OP_LSR,
      OP_ASR, OP_ROR: begin
        alu_res = sh_res;
        alu_c   = sh_c;
      end
    endcase
  end

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign in_ready = (state_q == ST_IDLE)
                 && (!out_valid || out_ready);
  assign busy     = (state_q == ST_MUL);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state, load strobe and multiply start
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt == '0) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // shift-add multiply, one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      mul_cin <= 1'b0;
    end else if (mul_start) begin
      acc     <= '0;
      mcand   <= a;
      mplier  <= b;
      cnt     <= CW'(WIDTH - 1);
      mul_cin <= cin;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // output register source
  always_comb begin
    ld_res = alu_res;
    ld_c   = alu_c;
    ld_v   = alu_v;
    if (state_q == ST_MUL) begin
      ld_res = acc_nxt;
      ld_c   = mul_cin;
      ld_v   = 1'b0;
    end
  end

  // output register and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      n         <= 1'b0;
      z         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        result    <= ld_res;
        n         <= ld_res[WIDTH-1];
        z         <= (ld_res == '0);
        c         <= ld_c;
        v         <= ld_v;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench with a
// behavioural model of the ALU (WIDTH=32).
module tb_alu_multicycle;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        n, z, c, v;
  logic        busy;

  logic ready_fix = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_ready = 1'b1;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  assign out_ready = rand_ready ? rnd_ready : ready_fix;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .n         (n),
    .z         (z),
    .c         (c),
    .v         (v),
    .busy      (busy)
  );

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x0,
                                 input logic [31:0] y0,
                                 input logic ci);
    exp_t            e;
    logic [31:0]     r, x, y;
    logic            cy, ov, k;
    longint unsigned full;
    longint          ss;
    int              s, rr;
    r = '0; cy = ci; ov = 1'b0; k = 1'b0;
    x = x0; y = y0;
    s = int'(y0[7:0]);
    case (o)
      4'h0: r = x0 & y0;
      4'h1: r = x0 | y0;
      4'h2: r = x0 ^ y0;
      4'h3: r = x0 & ~y0;
      4'h4: r = y0;
      4'h5: r = ~y0;
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
        case (o)
          4'h7: k = ci;
          4'h8: begin y = ~y0; k = 1'b1; end
          4'h9: begin y = ~y0; k = ci; end
          4'hA: begin x = y0; y = ~x0; k = 1'b1; end
          default: ;
        endcase
        full = {32'b0, x} + {32'b0, y} + 64'(k);
        r  = full[31:0];
        cy = full[32];
        ss = longint'($signed(x)) + longint'($signed(y))
           + longint'(k);
        ov = (ss > 64'sd2147483647)
          || (ss < -64'sd2147483648);
      end
      4'hB: begin
        full = {32'b0, x0} * {32'b0, y0};
        r = full[31:0];
      end
      4'hC: begin
        if (s == 0) r = x0;
        else if (s <= 32) begin
          full = {32'b0, x0} << s;
          r = full[31:0];
          cy = full[32];
        end else begin
          r = '0; cy = 1'b0;
        end
      end
      4'hD: begin
        if (s == 0) r = x0;
        else if (s <= 32) begin
          r = x0 >> s;
          cy = x0[s-1];
        end else begin
          r = '0; cy = 1'b0;
        end
      end
      4'hE: begin
        if (s == 0) r = x0;
        else if (s < 32) begin
          r = $signed(x0) >>> s;
          cy = x0[s-1];
        end else begin
          r = {32{x0[31]}};
          cy = x0[31];
        end
      end
      default: begin
        if (s == 0) r = x0;
        else begin
          rr = s % 32;
          r = (x0 >> rr) | (x0 << (32 - rr));
          cy = r[31];
        end
      end
    endcase
    e.r = r;
    e.n = r[31];
    e.z = (r == 0);
    e.c = cy;
    e.v = ov;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", nm, act, want);
    end
  endtask

  // present one op and wait (bounded) for acceptance
  task automatic send(input logic [3:0] o,
                      input logic [31:0] x,
                      input logic [31:0] y,
                      input logic ci);
    bit ok;
    ok = 1'b0;
    op = o; a = x; b = y; cin = ci;
    in_valid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(o, x, y, ci));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: op %h never accepted", o);
    end
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: every output transfer is checked against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got %h, wanted none",
                 {result, n, z, c, v});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_out", {result, n, z, c, v}, e);
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    logic [3:0]  o;
    int          k;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {out_valid, busy, result, n, z, c, v}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send(4'h6, 32'h7FFFFFFF, 32'h1, 1'b0);
    chk("add_ovf", {out_valid, result, n, z, c, v},
        {1'b1, 32'h80000000, 4'b1001});
    send(4'h8, 32'h5, 32'h5, 1'b0);
    chk("sub_eq", {out_valid, result, n, z, c, v},
        {1'b1, 32'h0, 4'b0110});
    send(4'h9, 32'h0, 32'h0, 1'b0);
    chk("sbc_zero", {out_valid, result, n, z, c, v},
        {1'b1, 32'hFFFFFFFF, 4'b1000});
    send(4'hE, 32'h80000000, 32'd40, 1'b0);
    chk("asr_40", {result, n, z, c, v},
        {32'hFFFFFFFF, 4'b1010});
    send(4'hF, 32'h1, 32'd33, 1'b0);
    chk("ror_33", {result, n, z, c, v},
        {32'h80000000, 4'b1010});
    send(4'hC, 32'h1, 32'd0, 1'b1);
    chk("lsl_0", {result, n, z, c, v}, {32'h1, 4'b0010});

    send(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    for (int j = 0; j < W; j++) begin
      chk("mul_busy", {busy, in_ready, out_valid}, 3'b100);
      @(posedge clk);
      #1;
    end
    chk("mul_done", {busy, in_ready, out_valid, result,
                     n, z, c, v},
        {3'b011, 32'h1, 4'b0010});

    @(posedge clk);
    #1;
    ready_fix = 1'b0;
    send(4'h6, 32'd10, 32'd20, 1'b0);
    op = 4'h8; a = 32'd100; b = 32'd1; cin = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, result, n, z, c, v},
          {1'b1, 32'd30, 4'b0000});
      @(posedge clk);
      #1;
    end
    ready_fix = 1'b1;
    send(4'h8, 32'd100, 32'd1, 1'b0);
    chk("bp_next", {out_valid, result, n, z, c, v},
        {1'b1, 32'd99, 4'b0010});

    @(posedge clk);
    #1;
    send(4'hB, 32'd3, 32'd4, 1'b1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rr_zero", {out_valid, busy, result, n, z, c, v}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rr_ready", {in_ready, busy}, 2'b10);
    @(posedge clk);
    #1;
    send(4'h6, 32'd2, 32'd3, 1'b0);
    chk("rr_add", {out_valid, result, n, z, c, v},
        {1'b1, 32'd5, 4'b0000});
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("rr_no_stale", {out_valid, busy}, 0);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 2) == 0)
        y = 32'($urandom_range(0, 70));
      if ($urandom_range(0, 7) == 0)
        x = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF
                                        : 32'h80000000;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(o, x, y, 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    ready_fix = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
